snake_game_ctrl: RTL and testbench

//  Game-state controller and apple-eat detector for the snake game; feeds the score display stage.

---
 rtl/snake_pkg.sv | 13 +
 rtl/key_debounce.sv | 42 ++++
 rtl/snake_game_ctrl.sv | 131 +++++++++++++
 tb/tb_snake_game_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared game-state encoding and grid defaults for the snake game
package snake_pkg;

    // One-hot game states; the score display decodes Game_status with these same values.
    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } game_state_e;

    localparam int SNAKE_COORD_W = 6;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser, stable-time debounce and press pulse for an active-low key
module key_debounce #(
    parameter int DB_CYCLES = 480_000
) (
    input  logic Clk_24mhz,
    input  logic Rst_n,
    input  logic Key_raw,
    output logic Key_press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             key_level;
    logic [CNT_W-1:0] stable_cnt;

    // Idle level of the key is high, so synchroniser and debounced level reset to 1.
    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            key_level  <= 1'b1;
            stable_cnt <= '0;
            Key_press  <= 1'b0;
        end else begin
            sync_1    <= Key_raw;
            sync_2    <= sync_1;
            Key_press <= 1'b0;
            if (sync_2 == key_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DB_CYCLES - 1)) begin
                key_level  <= sync_2;
                stable_cnt <= '0;
                Key_press  <= ~sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - START/PLAY/END controller and apple-eat detector; SNAKE_PAUSE_EN adds pause key
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int DB_CYCLES        = 480_000,
    parameter int END_HOLD_CYCLES  = 48_000_000,
    parameter int ADD_PULSE_CYCLES = 4,
    parameter int COORD_W          = SNAKE_COORD_W
) (
    input  logic               Clk_24mhz,
    input  logic               Rst_n,
    input  logic               Key_start,
`ifdef SNAKE_PAUSE_EN
    input  logic               Key_pause,
`endif
    input  logic               Move_tick,
    input  logic               Hit_wall,
    input  logic               Hit_body,
    input  logic [COORD_W-1:0] Head_x,
    input  logic [COORD_W-1:0] Head_y,
    input  logic [COORD_W-1:0] Apple_x,
    input  logic [COORD_W-1:0] Apple_y,
    output logic [2:0]         Game_status,
    output logic               Body_add_sig,
    output logic               Apple_respawn,
    output logic               Game_pause
);

    localparam int HOLD_W = $clog2(END_HOLD_CYCLES + 1);
    localparam int ADD_W  = $clog2(ADD_PULSE_CYCLES + 1);

    game_state_e       state_q;
    game_state_e       state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADD_W-1:0]  add_cnt;
    logic              start_press;
    logic              pause_q;
    logic              tick;
    logic              hit;
    logic              eat;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .Clk_24mhz (Clk_24mhz),
        .Rst_n     (Rst_n),
        .Key_raw   (Key_start),
        .Key_press (start_press)
    );

`ifdef SNAKE_PAUSE_EN
    logic pause_press;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
        .Clk_24mhz (Clk_24mhz),
        .Rst_n     (Rst_n),
        .Key_raw   (Key_pause),
        .Key_press (pause_press)
    );

    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            pause_q <= 1'b0;
        end else if (state_d != ST_PLAY) begin
            pause_q <= 1'b0;
        end else if (state_q == ST_PLAY && pause_press) begin
            pause_q <= ~pause_q;
        end
    end
`else
    assign pause_q = 1'b0;
`endif

    // A paused game sees neither moves nor start presses.
    assign tick = Move_tick & ~pause_q;
    assign hit  = Hit_wall | Hit_body;
    assign eat  = (state_q == ST_PLAY) && tick && !hit
                  && (Head_x == Apple_x) && (Head_y == Apple_y);

    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (start_press && !pause_q)        state_d = ST_PLAY;
            ST_PLAY:  if (tick && hit)                    state_d = ST_END;
            ST_END:   if (start_press && hold_cnt == '0)  state_d = ST_START;
            default:                                      state_d = ST_START;
        endcase
    end

    always_comb begin
        Game_status  = state_q;
        Body_add_sig = (add_cnt != '0);
        Game_pause   = pause_q;
    end

    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_cnt <= '0;
        end else if (state_q != ST_END && state_d == ST_END) begin
            hold_cnt <= HOLD_W'(END_HOLD_CYCLES);
        end else if (state_q == ST_END && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Eats are only accepted with the counter idle, so a pulse is never extended
    // and the output drops for at least one cycle between pulses.
    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            add_cnt       <= '0;
            Apple_respawn <= 1'b0;
        end else begin
            Apple_respawn <= 1'b0;
            if (state_d != ST_PLAY) begin
                add_cnt <= '0;
            end else if (eat && add_cnt == '0) begin
                add_cnt       <= ADD_W'(ADD_PULSE_CYCLES);
                Apple_respawn <= 1'b1;
            end else if (add_cnt != '0) begin
                add_cnt <= add_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;

    localparam int CW = 6;

    logic          Clk_24mhz = 1'b0;
    logic          Rst_n     = 1'b0;
    logic          Key_start = 1'b1;
`ifdef SNAKE_PAUSE_EN
    logic          Key_pause = 1'b1;
`endif
    logic          Move_tick = 1'b0;
    logic          Hit_wall  = 1'b0;
    logic          Hit_body  = 1'b0;
    logic [CW-1:0] Head_x    = '0;
    logic [CW-1:0] Head_y    = '0;
    logic [CW-1:0] Apple_x   = 6'd1;
    logic [CW-1:0] Apple_y   = 6'd1;
    logic [2:0]    Game_status;
    logic          Body_add_sig;
    logic          Apple_respawn;
    logic          Game_pause;

    int checks   = 0;
    int failures = 0;

    always #5 Clk_24mhz = ~Clk_24mhz;

    snake_game_ctrl #(
        .DB_CYCLES        (8),
        .END_HOLD_CYCLES  (32),
        .ADD_PULSE_CYCLES (4),
        .COORD_W          (CW)
    ) dut (
        .Clk_24mhz     (Clk_24mhz),
        .Rst_n         (Rst_n),
        .Key_start     (Key_start),
`ifdef SNAKE_PAUSE_EN
        .Key_pause     (Key_pause),
`endif
        .Move_tick     (Move_tick),
        .Hit_wall      (Hit_wall),
        .Hit_body      (Hit_body),
        .Head_x        (Head_x),
        .Head_y        (Head_y),
        .Apple_x       (Apple_x),
        .Apple_y       (Apple_y),
        .Game_status   (Game_status),
        .Body_add_sig  (Body_add_sig),
        .Apple_respawn (Apple_respawn),
        .Game_pause    (Game_pause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk_24mhz);
    endtask

    // Key held 12 cycles then released 12 cycles; counts Game_status changes seen.
    task automatic press_start(output int changes);
        logic [2:0] prev;
        prev    = Game_status;
        changes = 0;
        Key_start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) Key_start = 1'b1;
            @(negedge Clk_24mhz);
            if (Game_status != prev) changes++;
            prev = Game_status;
        end
    endtask

    task automatic tick();
        Move_tick = 1'b1;
        @(negedge Clk_24mhz);
        Move_tick = 1'b0;
    endtask

    // Samples the cycle after a tick and the following ones.
    task automatic watch_pulse(output int high, output int resp, output int first);
        high  = 0;
        resp  = 0;
        first = Body_add_sig;
        for (int i = 0; i < 8; i++) begin
            high += int'(Body_add_sig);
            resp += int'(Apple_respawn);
            @(negedge Clk_24mhz);
        end
    endtask

`ifdef SNAKE_PAUSE_EN
    task automatic press_pause();
        Key_pause = 1'b0;
        cyc(12);
        Key_pause = 1'b1;
        cyc(12);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg;
        int high;
        int resp;
        int first;

        cyc(3);
        check("rst_status", Game_status, 3'b001);
        check("rst_body", Body_add_sig, 1'b0);
        check("rst_respawn", Apple_respawn, 1'b0);
        check("rst_pause", Game_pause, 1'b0);
        Rst_n = 1'b1;
        cyc(2);

        // Ticks with a hit and an apple match are ignored in START.
        Head_x = 6'd5; Head_y = 6'd7; Apple_x = 6'd5; Apple_y = 6'd7;
        Hit_wall = 1'b1;
        tick();
        Hit_wall = 1'b0;
        watch_pulse(high, resp, first);
        check("start_tick_status", Game_status, 3'b001);
        check("start_tick_body", high, 0);

        // Short glitch is filtered.
        Key_start = 1'b0;
        cyc(3);
        Key_start = 1'b1;
        cyc(20);
        check("glitch_status", Game_status, 3'b001);

        press_start(chg);
        check("press_changes", chg, 1);
        check("press_play", Game_status, 3'b010);

        // Eat at (5,7).
        tick();
        watch_pulse(high, resp, first);
        check("eat_first", first, 1'b1);
        check("eat_high", high, 4);
        check("eat_respawn", resp, 1);

        // Head off the apple: no pulse.
        Head_y = 6'd8;
        tick();
        watch_pulse(high, resp, first);
        check("miss_high", high, 0);
        check("miss_respawn", resp, 0);
        Head_y = 6'd7;

        // Second eat while the pulse is high is dropped.
        tick();
        high = int'(Body_add_sig);
        resp = int'(Apple_respawn);
        for (int i = 1; i < 10; i++) begin
            if (i == 1) Move_tick = 1'b1;
            @(negedge Clk_24mhz);
            Move_tick = 1'b0;
            high += int'(Body_add_sig);
            resp += int'(Apple_respawn);
        end
        check("drop_high", high, 4);
        check("drop_respawn", resp, 1);

        // Hit and eat on the same tick: hit wins.
        Hit_body = 1'b1;
        tick();
        Hit_body = 1'b0;
        check("hit_status", Game_status, 3'b100);
        watch_pulse(high, resp, first);
        check("hit_body", high, 0);
        check("hit_respawn", resp, 0);

        // Early press in END is ignored; later ones restart.
        press_start(chg);
        check("end_early", Game_status, 3'b100);
        cyc(20);
        press_start(chg);
        check("end_restart", Game_status, 3'b001);
        press_start(chg);
        check("restart_play", Game_status, 3'b010);

        // Reset during the pulse.
        tick();
        check("rst_mid_c1", Body_add_sig, 1'b1);
        @(negedge Clk_24mhz);
        check("rst_mid_c2", Body_add_sig, 1'b1);
        Rst_n = 1'b0;
        #1;
        check("rst_mid_body", Body_add_sig, 1'b0);
        check("rst_mid_status", Game_status, 3'b001);
        @(negedge Clk_24mhz);
        Rst_n = 1'b1;
        cyc(2);

`ifdef SNAKE_PAUSE_EN
        press_start(chg);
        check("p_play", Game_status, 3'b010);
        press_pause();
        check("p_on", Game_pause, 1'b1);
        tick();
        watch_pulse(high, resp, first);
        check("p_no_eat", high, 0);
        Hit_wall = 1'b1;
        tick();
        Hit_wall = 1'b0;
        cyc(1);
        check("p_no_hit", Game_status, 3'b010);
        press_pause();
        check("p_off", Game_pause, 1'b0);
        tick();
        watch_pulse(high, resp, first);
        check("p_eat_after", high, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
